// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared widths, funct3 encodings and the LSU state type
// for the MEM-stage load/store unit.
package load_store_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ0 = 3'd1,
    ST_RSP0 = 3'd2,
    ST_REQ1 = 3'd3,
    ST_RSP1 = 3'd4,
    ST_DONE = 3'd5
  } lsu_state_t;

  // Byte-enable pattern of an access before lane shifting. An all-zero
  // result marks an undefined funct3 encoding.
  function automatic logic [BE_WIDTH-1:0] access_mask(input logic isStore,
                                                      input logic [2:0] funct3);
    logic [BE_WIDTH-1:0] mask;
    mask = '0;
    if (isStore) begin
      case (funct3)
        FUNCT3_SB: mask = 4'b0001;
        FUNCT3_SH: mask = 4'b0011;
        FUNCT3_SW: mask = 4'b1111;
        default:   mask = '0;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LBU: mask = 4'b0001;
        FUNCT3_LH, FUNCT3_LHU: mask = 4'b0011;
        FUNCT3_LW:             mask = 4'b1111;
        default:               mask = '0;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// lsu_load_align: purely combinational load formatter. Takes the two bus
// words of an access, the byte offset and funct3, and returns the sized,
// sign- or zero-extended load result.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_word0,
  input  logic [DATA_WIDTH-1:0] i_word1,
  input  logic [1:0]            i_off,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  // Slide the word pair right so the addressed byte lands at bit 0.
  always_comb begin
    w_shifted = DATA_WIDTH'({i_word1, i_word0} >> {i_off, 3'b000});
  end

  // Trim to the access size and extend; undefined encodings read as zero.
  always_comb begin
    o_data = '0;
    case (i_funct3)
      FUNCT3_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      FUNCT3_LH:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      FUNCT3_LW:  o_data = w_shifted;
      FUNCT3_LBU: o_data = {24'b0, w_shifted[7:0]};
      FUNCT3_LHU: o_data = {16'b0, w_shifted[15:0]};
      default:    o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data-bus initiator. Converts load/store controls
// into a single outstanding req/gnt/rvalid transaction, builds byte enables and
// lane-rotated store data, and formats load results. The pipeline is stalled
// until the access reaches DONE.
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses
// into two bus transactions; without it such accesses are rejected through
// misalign_o without touching the bus.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_MemRead_en,
  input  logic                  MEM_MemWrite_en,
  input  logic [2:0]            MEM_funct3_i,
  input  logic [DATA_WIDTH-1:0] MEM_addr_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  output logic                  stall_o,
  output logic                  ld_valid_o,
  output logic [DATA_WIDTH-1:0] ld_data_o,
  output logic                  misalign_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_WIDTH-1:0] bus_addr_o,
  output logic [BE_WIDTH-1:0]   bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_t r_state;
  lsu_state_t w_next;

  logic                  w_access;
  logic                  w_isStore;
  logic                  w_isLoad;
  logic [1:0]            w_off;
  logic [BE_WIDTH-1:0]   w_mask;
  logic                  w_defined;
  logic                  w_crosses;
  logic                  w_split;
  logic                  w_reject;
  logic [2*BE_WIDTH-1:0] w_beShifted;
  logic [DATA_WIDTH-1:0] w_wordAddr0;
  logic [DATA_WIDTH-1:0] w_wordAddr1;
  logic [DATA_WIDTH-1:0] w_wdataRot;
  logic [DATA_WIDTH-1:0] w_alignWord0;
  logic [DATA_WIDTH-1:0] w_alignWord1;
  logic [DATA_WIDTH-1:0] w_loadResult;

  logic                  r_busReq;
  logic                  r_busWe;
  logic [DATA_WIDTH-1:0] r_busAddr;
  logic [BE_WIDTH-1:0]   r_busBe;
  logic [DATA_WIDTH-1:0] r_busWdata;
  logic [DATA_WIDTH-1:0] r_word0;
  logic                  r_ldValid;
  logic [DATA_WIDTH-1:0] r_ldData;
  logic                  r_misalign;

  // Decode the MEM-stage request: kind, size, lane offset and whether it
  // spills into the next word. Both enables together count as a store.
  always_comb begin
    w_access    = MEM_MemRead_en | MEM_MemWrite_en;
    w_isStore   = MEM_MemWrite_en;
    w_isLoad    = MEM_MemRead_en & ~MEM_MemWrite_en;
    w_off       = MEM_addr_i[1:0];
    w_mask      = access_mask(w_isStore, MEM_funct3_i);
    w_defined   = |w_mask;
    w_crosses   = ((w_mask == 4'b0011) && (w_off == 2'd3)) ||
                  ((w_mask == 4'b1111) && (w_off != 2'd0));
    w_split     = w_crosses & SPLIT_EN;
    w_reject    = w_crosses & ~SPLIT_EN;
    w_beShifted = {4'b0000, w_mask} << w_off;
    w_wordAddr0 = {MEM_addr_i[DATA_WIDTH-1:2], 2'b00};
    w_wordAddr1 = w_wordAddr0 + 32'd4;
  end

  // Rotate store data left by the byte offset so each byte sits on its lane;
  // bytes that wrap around belong to the second word of a split store.
  always_comb begin
    w_wdataRot = MEM_wr_data_i;
    case (w_off)
      2'd0: w_wdataRot = MEM_wr_data_i;
      2'd1: w_wdataRot = {MEM_wr_data_i[23:0], MEM_wr_data_i[31:24]};
      2'd2: w_wdataRot = {MEM_wr_data_i[15:0], MEM_wr_data_i[31:16]};
      2'd3: w_wdataRot = {MEM_wr_data_i[7:0],  MEM_wr_data_i[31:8]};
      default: w_wdataRot = MEM_wr_data_i;
    endcase
  end

  // Feed the aligner with the word arriving this cycle, falling back to the
  // captured first word once the second response is in flight.
  always_comb begin
    w_alignWord0 = (r_state == ST_RSP0) ? bus_rdata_i : r_word0;
    w_alignWord1 = (r_state == ST_RSP1) ? bus_rdata_i : '0;
  end

  lsu_load_align u_load_align (
    .i_word0  (w_alignWord0),
    .i_word1  (w_alignWord1),
    .i_off    (w_off),
    .i_funct3 (MEM_funct3_i),
    .o_data   (w_loadResult)
  );

  // Next-state logic and the combinational pipeline stall.
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          stall_o = 1'b1;
          if (!w_defined || w_reject) w_next = ST_DONE;
          else                        w_next = ST_REQ0;
        end
      end
      ST_REQ0: begin
        stall_o = 1'b1;
        if (bus_gnt_i) begin
          if (w_isStore) w_next = w_split ? ST_REQ1 : ST_DONE;
          else           w_next = ST_RSP0;
        end
      end
      ST_RSP0: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) w_next = w_split ? ST_REQ1 : ST_DONE;
      end
      ST_REQ1: begin
        stall_o = 1'b1;
        if (bus_gnt_i) w_next = w_isStore ? ST_DONE : ST_RSP1;
      end
      ST_RSP1: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Bus request fields are loaded when a request phase starts and held
  // untouched until the grant arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busBe    <= '0;
      r_busWdata <= '0;
    end else begin
      r_busReq <= (w_next == ST_REQ0) || (w_next == ST_REQ1);
      if ((r_state == ST_IDLE) && (w_next == ST_REQ0)) begin
        r_busWe    <= w_isStore;
        r_busAddr  <= w_wordAddr0;
        r_busBe    <= w_isStore ? w_beShifted[BE_WIDTH-1:0] : '1;
        r_busWdata <= w_isStore ? w_wdataRot : '0;
      end else if ((w_next == ST_REQ1) && (r_state != ST_REQ1)) begin
        r_busAddr <= w_wordAddr1;
        r_busBe   <= w_isStore ? w_beShifted[2*BE_WIDTH-1:BE_WIDTH] : '1;
      end
    end
  end

  // Capture the first read word and register the completion pulses and load
  // result as the access enters DONE. An undefined load completes with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word0    <= '0;
      r_ldValid  <= 1'b0;
      r_ldData   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_ldValid  <= 1'b0;
      r_misalign <= 1'b0;
      if ((r_state == ST_RSP0) && bus_rvalid_i) r_word0 <= bus_rdata_i;
      if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
        r_misalign <= (r_state == ST_IDLE) & w_reject;
        r_ldValid  <= w_isLoad & ~w_reject;
        if (w_isLoad) r_ldData <= (w_defined && !w_reject) ? w_loadResult : '0;
      end
    end
  end

  assign bus_req_o   = r_busReq;
  assign bus_we_o    = r_busWe;
  assign bus_addr_o  = r_busAddr;
  assign bus_be_o    = r_busBe;
  assign bus_wdata_o = r_busWdata;
  assign ld_valid_o  = r_ldValid;
  assign ld_data_o   = r_ldData;
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit. A byte-level
// memory reference model predicts every bus beat, load result and misalign
// pulse; a bus responder with random grant/response delays serves the DUT,
// and a monitor compares each observed event with the queued prediction.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] memAddr;
  logic [31:0] storeData;
  logic        stall;
  logic        ldValid;
  logic [31:0] ldData;
  logic        misalign;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busGnt = 1'b0;
  logic        busRvalid = 1'b0;
  logic [31:0] busRdata = '0;

  load_store_unit dut (
    .clk             (clk),
    .rst             (rst),
    .MEM_MemRead_en  (memRead),
    .MEM_MemWrite_en (memWrite),
    .MEM_funct3_i    (funct3),
    .MEM_addr_i      (memAddr),
    .MEM_wr_data_i   (storeData),
    .stall_o         (stall),
    .ld_valid_o      (ldValid),
    .ld_data_o       (ldData),
    .misalign_o      (misalign),
    .bus_req_o       (busReq),
    .bus_we_o        (busWe),
    .bus_addr_o      (busAddr),
    .bus_be_o        (busBe),
    .bus_wdata_o     (busWdata),
    .bus_gnt_i       (busGnt),
    .bus_rvalid_i    (busRvalid),
    .bus_rdata_i     (busRdata)
  );

  always #5 clk = ~clk;

  // kind: 0 = bus beat accepted, 1 = load result, 2 = misalign pulse
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
  } ev_t;

  ev_t         expQ[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] memInit [logic [31:0]];
  int          gntWait = 0;
  int          gntMax = 0;
  int          rvMin = 0;
  int          rvMax = 0;
  int          rdWait = 0;
  bit          rdPending = 1'b0;
  logic [31:0] rdAddr = '0;
  int          stallCycles;

  function automatic logic [31:0] memWord(input logic [31:0] w);
    if (memInit.exists(w)) return memInit[w];
    return {w[15:0], ~w[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [7:0] memByte(input logic [31:0] a);
    logic [31:0] word;
    int lane;
    word = memWord(a & ~32'd3);
    lane = int'(a[1:0]);
    return word[8*lane +: 8];
  endfunction

  function automatic logic [31:0] beMask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: predicts the observable events of one access from
  // byte addresses and sizes.
  task automatic pushExpected(input bit r, input bit w, input logic [2:0] fn,
                              input logic [31:0] a, input logic [31:0] d);
    int size;
    int nWords;
    bit isStore;
    bit isLoad;
    bit crosses;
    ev_t e;
    logic [31:0] wa;
    logic [31:0] ba;
    logic [31:0] v;
    isStore = w;
    isLoad  = r && !w;
    if (!r && !w) return;
    size = 0;
    if (isStore) begin
      if (fn == 3'd0) size = 1;
      else if (fn == 3'd1) size = 2;
      else if (fn == 3'd2) size = 4;
    end else begin
      if (fn == 3'd0 || fn == 3'd4) size = 1;
      else if (fn == 3'd1 || fn == 3'd5) size = 2;
      else if (fn == 3'd2) size = 4;
    end
    if (size == 0) begin
      if (isLoad) begin
        e = '{kind: 1, addr: '0, we: 1'b0, be: '0, data: '0};
        expQ.push_back(e);
      end
      return;
    end
    crosses = (int'(a[1:0]) + size) > 4;
    if (crosses && !SPLIT) begin
      e = '{kind: 2, addr: '0, we: 1'b0, be: '0, data: '0};
      expQ.push_back(e);
      return;
    end
    nWords = crosses ? 2 : 1;
    for (int k = 0; k < nWords; k++) begin
      wa = (a & ~32'd3) + 32'(4 * k);
      e = '{kind: 0, addr: wa, we: isStore, be: 4'hF, data: '0};
      if (isStore) begin
        e.be = '0;
        for (int i = 0; i < size; i++) begin
          ba = a + 32'(i);
          if ((ba & ~32'd3) == wa) begin
            e.be[ba[1:0]] = 1'b1;
            e.data[8*int'(ba[1:0]) +: 8] = d[8*i +: 8];
          end
        end
      end
      expQ.push_back(e);
    end
    if (isLoad) begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = memByte(a + 32'(i));
      if (fn[2] == 1'b0) begin
        if (size == 1) v = {{24{v[7]}}, v[7:0]};
        if (size == 2) v = {{16{v[15]}}, v[15:0]};
      end
      e = '{kind: 1, addr: '0, we: 1'b0, be: '0, data: v};
      expQ.push_back(e);
    end
  endtask

  // Issue one access, hold it while stalled, and report how many cycles
  // the pipeline was frozen.
  task automatic applyStimulus(input bit r, input bit w, input logic [2:0] fn,
                               input logic [31:0] a, input logic [31:0] d,
                               output int cycles);
    @(posedge clk); #1;
    pushExpected(r, w, fn, a, d);
    memRead = r; memWrite = w; funct3 = fn; memAddr = a; storeData = d;
    cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall) break;
      cycles++;
    end
    if (cycles >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: actual=stall after 200 cycles required=DONE");
    end
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic checkEvent(input int kind);
    ev_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_event: actual=kind %0d required=none", kind);
      return;
    end
    e = expQ.pop_front();
    checkOutput("event_kind", 32'(kind), 32'(e.kind));
    if (kind != e.kind) return;
    if (kind == 0) begin
      checkOutput("bus_addr", busAddr, e.addr);
      checkOutput("bus_we", {31'b0, busWe}, {31'b0, e.we});
      checkOutput("bus_be", {28'b0, busBe}, {28'b0, e.be});
      if (e.we) checkOutput("bus_wdata", busWdata & beMask(e.be), e.data);
    end else if (kind == 1) begin
      checkOutput("ld_data", ldData, e.data);
    end
  endtask

  // Monitor: every accepted bus beat, load result or misalign pulse is
  // matched against the head of the prediction queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (busReq && busGnt) checkEvent(0);
      if (ldValid) checkEvent(1);
      if (misalign) checkEvent(2);
    end
  end

  // Bus responder: grants after a configurable delay and returns read data
  // from the memory image some cycles after the grant.
  initial begin
    forever begin
      @(posedge clk); #1;
      busGnt = 1'b0;
      busRvalid = 1'b0;
      busRdata = $urandom;
      if (rdPending) begin
        if (rdWait == 0) begin
          busRvalid = 1'b1;
          busRdata = memWord(rdAddr);
          rdPending = 1'b0;
        end else begin
          rdWait--;
        end
      end
      if (busReq) begin
        if (gntWait == 0) begin
          busGnt = 1'b1;
          if (!busWe) begin
            rdPending = 1'b1;
            rdAddr = busAddr;
            rdWait = $urandom_range(rvMin, rvMax);
          end
          gntWait = $urandom_range(0, gntMax);
        end else begin
          gntWait--;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = '0; memAddr = '0; storeData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_req", {31'b0, busReq}, 32'd0);
    checkOutput("rst_we", {31'b0, busWe}, 32'd0);
    checkOutput("rst_ld_valid", {31'b0, ldValid}, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("rst_addr", busAddr, 32'd0);
    checkOutput("rst_be", {28'b0, busBe}, 32'd0);
    checkOutput("rst_wdata", busWdata, 32'd0);
    checkOutput("rst_ld_data", ldData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed: LW latency");
    memInit[32'h100] = 32'hDEAD_BEEF;
    applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, stallCycles);
    checkOutput("lw_stall_cycles", 32'(stallCycles), 32'd3);

    $display("[TB] directed: SB lane 3");
    applyStimulus(0, 1, 3'b000, 32'h203, 32'h0000_00A5, stallCycles);
    checkOutput("sb_stall_cycles", 32'(stallCycles), 32'd2);

    $display("[TB] directed: LB/LBU sign handling");
    memInit[32'h100] = 32'h0000_8000;
    applyStimulus(1, 0, 3'b000, 32'h101, 32'h0, stallCycles);
    applyStimulus(1, 0, 3'b100, 32'h101, 32'h0, stallCycles);

    $display("[TB] directed: reset during read response");
    rvMin = 3; rvMax = 3;
    memInit[32'h400] = 32'h0BAD_F00D;
    @(posedge clk); #1;
    pushExpected(1, 0, 3'b010, 32'h400, 32'h0);
    memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; memAddr = 32'h400;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1; memRead = 1'b0;
    @(posedge clk); #2;
    expQ.delete();
    checkOutput("abort_stall", {31'b0, stall}, 32'd0);
    checkOutput("abort_req", {31'b0, busReq}, 32'd0);
    checkOutput("abort_addr", busAddr, 32'd0);
    checkOutput("abort_be", {28'b0, busBe}, 32'd0);
    checkOutput("abort_ld_data", ldData, 32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_late_rvalid", {31'b0, ldValid}, 32'd0);
    checkOutput("abort_idle_stall", {31'b0, stall}, 32'd0);
    rvMin = 0; rvMax = 0;

    $display("[TB] directed: grant held off");
    gntWait = 5;
    @(posedge clk); #1;
    pushExpected(0, 1, 3'b010, 32'h300, 32'hCAFE_F00D);
    memWrite = 1'b1; memRead = 1'b0; funct3 = 3'b010; memAddr = 32'h300; storeData = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("hold_idle_stall", {31'b0, stall}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("hold_req", {31'b0, busReq}, 32'd1);
      checkOutput("hold_stall", {31'b0, stall}, 32'd1);
      checkOutput("hold_addr", busAddr, 32'h300);
      checkOutput("hold_be", {28'b0, busBe}, 32'hF);
      checkOutput("hold_wdata", busWdata, 32'hCAFE_F00D);
    end
    @(negedge clk);
    checkOutput("hold_done_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    memWrite = 1'b0;

    $display("[TB] directed: word access across a word boundary");
    memInit[32'h100] = 32'h1122_3344;
    memInit[32'h104] = 32'h5566_7788;
    applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, stallCycles);
    applyStimulus(0, 1, 3'b001, 32'h107, 32'hBEEF, stallCycles);

    $display("[TB] random accesses");
    gntMax = 3; rvMin = 0; rvMax = 3;
    for (int n = 0; n < 150; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 32'h1000 + 32'($urandom_range(0, 4095)),
                    $urandom, stallCycles);
    end

    repeat (4) @(posedge clk);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
